// File: rtl/nonce_scheduler.sv
// nonce_scheduler: job-level sequencer for the hashing module.
// Takes a nonce range and difficulty target from the host, issues one hash per
// nonce through begin/quit pulses, compares each result against the target and
// reports the first winning nonce or range exhaustion. A per-hash watchdog
// recovers a hung hash and retries the same nonce.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   job_valid/job_ready           host job handshake
//   job_nonce_start/_end/target   job range (inclusive, may wrap) and target
//   abort                         cancel the current job
//   hm_begin/hm_quit/hm_nonce     controls and nonce to the hashing module
//   hm_hash_done/hm_hash          result from the hashing module
//   found_valid/found_nonce/ack   winning nonce report and host consume
//   exhausted, timeout_err        single-cycle event pulses
//   busy                          high whenever not idle
module nonce_scheduler #(
  parameter int unsigned NONCE_W     = 32,
  parameter int unsigned HASH_W      = 256,
  parameter int unsigned TIMEOUT_CYC = 256
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               job_valid,
  output logic               job_ready,
  input  logic [NONCE_W-1:0] job_nonce_start,
  input  logic [NONCE_W-1:0] job_nonce_end,
  input  logic [HASH_W-1:0]  job_target,
  input  logic               abort,
  output logic               hm_begin,
  output logic               hm_quit,
  output logic [NONCE_W-1:0] hm_nonce,
  input  logic               hm_hash_done,
  input  logic [HASH_W-1:0]  hm_hash,
  output logic               found_valid,
  output logic [NONCE_W-1:0] found_nonce,
  input  logic               found_ack,
  output logic               exhausted,
  output logic               timeout_err,
  output logic               busy
);

  localparam int unsigned TMR_W = $clog2(TIMEOUT_CYC);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LAUNCH = 3'd1,
    S_WAIT   = 3'd2,
    S_QUIT   = 3'd3,
    S_REPORT = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic               ret_launch_q, ret_launch_d;
  logic [NONCE_W-1:0] nonce_q, nonce_d;
  logic [NONCE_W-1:0] end_q;
  logic [HASH_W-1:0]  target_q;
  logic [TMR_W-1:0]   timer_q;
  logic               job_latch;
  logic               found_load;
  logic               ev_exhaust;
  logic               ev_timeout;

  logic job_ready_d, hm_begin_d, hm_quit_d, found_valid_d, busy_d;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      ret_launch_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      ret_launch_q <= ret_launch_d;
    end
  end

  // Next-state logic; done outranks the watchdog, abort outranks both
  always_comb begin
    state_d      = state_q;
    ret_launch_d = ret_launch_q;
    nonce_d      = nonce_q;
    job_latch    = 1'b0;
    found_load   = 1'b0;
    ev_exhaust   = 1'b0;
    ev_timeout   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (job_valid) begin
          job_latch = 1'b1;
          nonce_d   = job_nonce_start;
          state_d   = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        if (abort) begin
          ret_launch_d = 1'b0;
          state_d      = S_QUIT;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (abort) begin
          ret_launch_d = 1'b0;
          state_d      = S_QUIT;
        end else if (hm_hash_done) begin
          if (hm_hash < target_q) begin
            found_load = 1'b1;
            state_d    = S_REPORT;
          end else if (nonce_q == end_q) begin
            ev_exhaust   = 1'b1;
            ret_launch_d = 1'b0;
            state_d      = S_QUIT;
          end else begin
            nonce_d      = nonce_q + NONCE_W'(1);
            ret_launch_d = 1'b1;
            state_d      = S_QUIT;
          end
        end else if (timer_q == TMR_W'(TIMEOUT_CYC - 1)) begin
          ev_timeout   = 1'b1;
          ret_launch_d = 1'b1;
          state_d      = S_QUIT;
        end
      end
      S_QUIT: begin
        state_d = (ret_launch_q && !abort) ? S_LAUNCH : S_IDLE;
      end
      S_REPORT: begin
        if (abort || found_ack) begin
          ret_launch_d = 1'b0;
          state_d      = S_QUIT;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic: state-decoded outputs are precomputed from the next state
  // and registered; the event pulses must coincide with the deciding WAIT cycle
  always_comb begin
    job_ready_d   = (state_d == S_IDLE);
    hm_begin_d    = (state_d == S_LAUNCH);
    hm_quit_d     = (state_d == S_QUIT);
    found_valid_d = (state_d == S_REPORT);
    busy_d        = (state_d != S_IDLE);
    exhausted     = ev_exhaust;
    timeout_err   = ev_timeout;
  end

  // Registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      job_ready   <= 1'b1;
      hm_begin    <= 1'b0;
      hm_quit     <= 1'b0;
      found_valid <= 1'b0;
      busy        <= 1'b0;
    end else begin
      job_ready   <= job_ready_d;
      hm_begin    <= hm_begin_d;
      hm_quit     <= hm_quit_d;
      found_valid <= found_valid_d;
      busy        <= busy_d;
    end
  end

  // Job datapath; hm_nonce only moves on entry to LAUNCH so it stays stable
  // across the whole hash, including the QUIT cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      nonce_q     <= '0;
      end_q       <= '0;
      target_q    <= '0;
      hm_nonce    <= '0;
      found_nonce <= '0;
    end else begin
      nonce_q <= nonce_d;
      if (job_latch) begin
        end_q    <= job_nonce_end;
        target_q <= job_target;
      end
      if (state_d == S_LAUNCH) hm_nonce <= nonce_d;
      if (found_load) found_nonce <= nonce_q;
    end
  end

  // Watchdog: cleared outside WAIT, so the first WAIT cycle sees zero
  always_ff @(posedge clk) begin
    if (rst) begin
      timer_q <= '0;
    end else if (state_q == S_WAIT) begin
      timer_q <= timer_q + TMR_W'(1);
    end else begin
      timer_q <= '0;
    end
  end

endmodule

// File: tb/tb_nonce_scheduler.sv
module tb_nonce_scheduler;
  localparam int unsigned NW  = 32;
  localparam int unsigned HW  = 256;
  localparam int unsigned TO  = 8;
  localparam int unsigned LAT = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          job_valid = 1'b0;
  logic          job_ready;
  logic [NW-1:0] job_nonce_start = '0;
  logic [NW-1:0] job_nonce_end = '0;
  logic [HW-1:0] job_target = '0;
  logic          abort = 1'b0;
  logic          hm_begin, hm_quit;
  logic [NW-1:0] hm_nonce;
  logic          hm_hash_done = 1'b0;
  logic [HW-1:0] hm_hash = '0;
  logic          found_valid;
  logic [NW-1:0] found_nonce;
  logic          found_ack = 1'b0;
  logic          exhausted, timeout_err, busy;

  nonce_scheduler #(.NONCE_W(NW), .HASH_W(HW), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst), .job_valid(job_valid), .job_ready(job_ready),
    .job_nonce_start(job_nonce_start), .job_nonce_end(job_nonce_end),
    .job_target(job_target), .abort(abort), .hm_begin(hm_begin),
    .hm_quit(hm_quit), .hm_nonce(hm_nonce), .hm_hash_done(hm_hash_done),
    .hm_hash(hm_hash), .found_valid(found_valid), .found_nonce(found_nonce),
    .found_ack(found_ack), .exhausted(exhausted), .timeout_err(timeout_err),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [HW-1:0] obs, input logic [HW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Hash model: answers LAT cycles after hm_begin; one launch of hang_nonce hangs
  logic [NW-1:0] hit_nonce  = 32'hDEAD_BEEF;
  logic [NW-1:0] hang_nonce = '0;
  logic          hang_armed = 1'b0;
  int            mcnt = 0;
  logic          mpend = 1'b0;
  logic [HW-1:0] hash_hit, hash_miss;
  initial begin
    hash_hit  = {8'h00, 8'hAB, 240'h0};
    hash_miss = '1;
  end

  always @(posedge clk) begin
    #1;
    if (rst || hm_quit) begin
      hm_hash_done = 1'b0;
      mpend = 1'b0;
    end else if (hm_begin) begin
      hm_hash_done = 1'b0;
      if (hang_armed && hm_nonce == hang_nonce) begin
        hang_armed = 1'b0;
        mpend = 1'b0;
      end else begin
        mpend = 1'b1;
        mcnt = LAT;
      end
    end else if (mpend) begin
      mcnt--;
      if (mcnt == 0) begin
        mpend = 1'b0;
        hm_hash_done = 1'b1;
        hm_hash = (hm_nonce == hit_nonce) ? hash_hit : hash_miss;
      end
    end
  end

  // Scoreboard of expected launch nonces plus event monitor
  logic [NW-1:0] exp_q[$];
  int n_begin = 0, n_quit = 0, n_exh = 0, n_to = 0, n_found = 0;
  int cyc = 0, last_begin_cyc = 0;
  logic prev_done = 1'b0, prev_found = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      if (hm_begin) begin
        n_begin++;
        last_begin_cyc = cyc;
        chk("sb_nonempty", 256'(exp_q.size() > 0), 256'(1));
        if (exp_q.size() > 0) chk("hm_nonce", 256'(hm_nonce), 256'(exp_q.pop_front()));
      end
      if (hm_quit) n_quit++;
      if (exhausted) begin
        n_exh++;
        chk("exh_with_done", 256'(hm_hash_done), 256'(1));
      end
      if (timeout_err) begin
        n_to++;
        chk("timeout_delay", 256'(cyc - last_begin_cyc), 256'(TO));
      end
      if (found_valid) n_found++;
      if (found_valid && !prev_found) chk("found_after_done", 256'(prev_done), 256'(1));
    end
    prev_done  = hm_hash_done;
    prev_found = found_valid;
  end

  task automatic clr_counts();
    n_begin = 0; n_quit = 0; n_exh = 0; n_to = 0; n_found = 0;
  endtask

  task automatic issue_job(input logic [NW-1:0] s, input logic [NW-1:0] e);
    @(negedge clk);
    job_valid = 1'b1; job_nonce_start = s; job_nonce_end = e;
    job_target = {8'h00, {248{1'b1}}};
    @(negedge clk);
    job_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while (!(job_ready && !busy) && n < budget) begin @(negedge clk); n++; end
    chk(tag, 256'(job_ready && !busy), 256'(1));
  endtask

  task automatic wait_found(input string tag, input int budget);
    int n = 0;
    while (!found_valid && n < budget) begin @(negedge clk); n++; end
    chk(tag, 256'(found_valid), 256'(1));
  endtask

  task automatic ack_and_close(input string tag);
    @(negedge clk); found_ack = 1'b1;
    @(negedge clk); found_ack = 1'b0;
    chk({tag, "_fv_drop"}, 256'(found_valid), 256'(0));
    chk({tag, "_quit"}, 256'(hm_quit), 256'(1));
    @(negedge clk);
    chk({tag, "_ready"}, 256'(job_ready), 256'(1));
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_job_ready", 256'(job_ready), 256'(1));
    chk("rst_busy", 256'(busy), 256'(0));
    chk("rst_outs", 256'({hm_begin, hm_quit, found_valid, exhausted, timeout_err}), 256'(0));
    chk("rst_nonces", 256'({hm_nonce, found_nonce}), 256'(0));

    // Single hit at 0x13
    clr_counts(); hit_nonce = 32'h13;
    for (int i = 'h10; i <= 'h13; i++) exp_q.push_back(NW'(i));
    issue_job(32'h10, 32'h20);
    wait_found("t1_found", 100);
    chk("t1_found_nonce", 256'(found_nonce), 256'(32'h13));
    chk("t1_begins", 256'(n_begin), 256'(4));
    chk("t1_quits", 256'(n_quit), 256'(3));
    repeat (3) @(negedge clk);
    chk("t1_hold_valid", 256'(found_valid), 256'(1));
    chk("t1_hold_nonce", 256'(found_nonce), 256'(32'h13));
    ack_and_close("t1");
    chk("t1_no_exh", 256'(n_exh), 256'(0));
    chk("t1_q_empty", 256'(exp_q.size()), 256'(0));

    // Exhaustion on a one-nonce range
    clr_counts(); hit_nonce = 32'hDEAD_BEEF;
    exp_q.push_back(32'h5);
    issue_job(32'h5, 32'h5);
    wait_idle("t2_idle", 50);
    chk("t2_begins", 256'(n_begin), 256'(1));
    chk("t2_quits", 256'(n_quit), 256'(1));
    chk("t2_exh", 256'(n_exh), 256'(1));
    chk("t2_no_found", 256'(n_found), 256'(0));

    // Wrap-around range
    clr_counts();
    exp_q.push_back(32'hFFFF_FFFE); exp_q.push_back(32'hFFFF_FFFF);
    exp_q.push_back(32'h0); exp_q.push_back(32'h1);
    issue_job(32'hFFFF_FFFE, 32'h1);
    wait_idle("t3_idle", 100);
    chk("t3_begins", 256'(n_begin), 256'(4));
    chk("t3_exh", 256'(n_exh), 256'(1));
    chk("t3_q_empty", 256'(exp_q.size()), 256'(0));

    // Watchdog: first launch of 0x7 hangs, retry hits
    clr_counts(); hit_nonce = 32'h7; hang_nonce = 32'h7; hang_armed = 1'b1;
    exp_q.push_back(32'h5); exp_q.push_back(32'h6);
    exp_q.push_back(32'h7); exp_q.push_back(32'h7);
    issue_job(32'h5, 32'h9);
    wait_found("t4_found", 100);
    chk("t4_timeouts", 256'(n_to), 256'(1));
    chk("t4_found_nonce", 256'(found_nonce), 256'(32'h7));
    chk("t4_begins", 256'(n_begin), 256'(4));
    chk("t4_quits", 256'(n_quit), 256'(3));
    ack_and_close("t4");

    // Abort together with a hitting result; mid-job job_valid ignored
    clr_counts(); hit_nonce = 32'h20;
    exp_q.push_back(32'h20);
    issue_job(32'h20, 32'h30);
    job_valid = 1'b1; job_nonce_start = 32'h999; job_nonce_end = 32'h999;
    @(negedge clk); job_valid = 1'b0;
    begin
      int n = 0;
      while (!hm_hash_done && n < 50) begin @(negedge clk); n++; end
      chk("t5_done_seen", 256'(hm_hash_done), 256'(1));
    end
    abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    chk("t5_quit", 256'(hm_quit), 256'(1));
    chk("t5_no_fv", 256'(found_valid), 256'(0));
    @(negedge clk);
    chk("t5_ready", 256'(job_ready), 256'(1));
    repeat (4) @(negedge clk);
    chk("t5_still_idle", 256'(busy), 256'(0));
    chk("t5_begins", 256'(n_begin), 256'(1));
    chk("t5_events", 256'(n_found + n_exh + n_to), 256'(0));

    // Reset during WAIT
    clr_counts(); hit_nonce = 32'hDEAD_BEEF;
    exp_q.push_back(32'h40);
    issue_job(32'h40, 32'h50);
    @(negedge clk);
    chk("t6_in_wait", 256'({busy, hm_begin}), 256'(2'b10));
    rst = 1'b1;
    @(negedge clk);
    chk("t6_rst_ready", 256'(job_ready), 256'(1));
    chk("t6_rst_outs", 256'({busy, hm_begin, hm_quit, found_valid}), 256'(0));
    chk("t6_rst_nonce", 256'(hm_nonce), 256'(0));
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("t6_no_quit", 256'(n_quit), 256'(0));
    chk("t6_idle", 256'(busy), 256'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/nonce_scheduler.md
Name: nonce_scheduler

Overview:
- Job-level sequencer for the hashing module. Accepts a mining job (nonce range plus difficulty target) from the host interface.
- Launches one hash per nonce by driving the hashing module's begin/quit controls, and compares each final hash against the target.
- Reports the first winning nonce, or signals range exhaustion.
- Includes a per-hash watchdog that recovers a hung hash and retries the same nonce.

Parameters:
- NONCE_W, 32, nonce width in bits.
- HASH_W, 256, hash/target width in bits.
- TIMEOUT_CYC, 256, cycles allowed between hm_begin and hm_hash_done before watchdog fires (>=2).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- job_valid  in  1  host presents a job
- job_ready  out  1  scheduler can accept a job
- job_nonce_start  in  NONCE_W  first nonce
- job_nonce_end  in  NONCE_W  last nonce, inclusive
- job_target  in  HASH_W  hit when hash < target, unsigned
- abort  in  1  cancel current job
- hm_begin  out  1  one-cycle begin_hash pulse to hashing module
- hm_quit  out  1  one-cycle quit_hash pulse to hashing module
- hm_nonce  out  NONCE_W  nonce under hash, stable from LAUNCH until next LAUNCH
- hm_hash_done  in  1  hashing module result ready (level)
- hm_hash  in  HASH_W  final hash, valid while hm_hash_done=1
- found_valid  out  1  winning nonce available
- found_nonce  out  NONCE_W  winning nonce
- found_ack  in  1  host consumed result
- exhausted  out  1  one-cycle pulse, range finished with no hit
- timeout_err  out  1  one-cycle pulse per watchdog expiry
- busy  out  1  high in every state except IDLE

Behaviour:
- Clocking and reset: single clock, synchronous active-high reset. On reset, state=IDLE; all outputs 0 except job_ready=1. hm_nonce, found_nonce, target and end registers are cleared to 0. Reset has top priority in every state.

State machine (IDLE, LAUNCH, WAIT, QUIT, REPORT):
- IDLE: job_ready=1. On job_valid, latch start/end/target, set nonce<=start, then go to LAUNCH. In this state, job_valid is accepted and abort is ignored.
- LAUNCH: hm_begin=1 for exactly one cycle. Clear the watchdog timer. Go to WAIT.
- WAIT: the timer increments each cycle.
  - If hm_hash_done=1:
    - hit (hm_hash < target): found_nonce<=nonce; go to REPORT.
    - else if nonce==end: exhausted=1 this cycle; go to QUIT with return=IDLE.
    - else: nonce<=nonce+1 mod 2^NONCE_W; go to QUIT with return=LAUNCH.
  - Else if timer==TIMEOUT_CYC-1: timeout_err=1; nonce unchanged; go to QUIT with return=LAUNCH. This retries the same nonce with no retry limit.
  - hm_hash_done takes priority over timeout in the same cycle.
- QUIT: hm_quit=1 for one cycle, then go to the return target.
- REPORT: found_valid=1 and found_nonce held stable. On found_ack, go to QUIT with return=IDLE. found_valid drops in the QUIT cycle.
- abort: in LAUNCH, WAIT or REPORT, go to QUIT with return=IDLE. No exhausted, found or timeout pulse in that cycle, even if hm_hash_done=1. abort in QUIT forces return=IDLE.

Timing and ranges:
- Nonce wrap: start>end is legal. Iterate start..2^NONCE_W-1, then 0..end. start==end hashes exactly one nonce. start==end+1 mod 2^NONCE_W covers the full 2^NONCE_W space.
- Per-nonce overhead, miss case: LAUNCH(1) + WAIT(hash latency) + QUIT(1).
- Result timing: found_valid rises the cycle after the WAIT cycle that saw the hit.
- Busy-time inputs: job_valid while busy is ignored and not queued. found_ack outside REPORT is ignored.

Test Plan:
- Single hit: start=0x10, end=0x20, target=0x00FF..FF. Model returns hash ≥ target for 0x10..0x12 and 0x00AB.. for 0x13 → three hm_begin/hm_quit pairs, then found_valid=1 and found_nonce=0x13 held until found_ack, then QUIT→IDLE with job_ready=1.
- Exhaustion: start=end=0x5, always miss → one hm_begin, exhausted pulses once, one hm_quit, IDLE; found_valid never high.
- Wrap: start=0xFFFFFFFE, end=0x1, always miss → hm_nonce sequence FFFFFFFE, FFFFFFFF, 0, 1; exhausted after the 4th hash.
- Watchdog: TIMEOUT_CYC=8, model never answers the first launch of nonce 0x7 → timeout_err 8 cycles after hm_begin, hm_quit, relaunch with hm_nonce=0x7; second attempt hits → found_nonce=0x7.
- Abort/priority: abort asserted in the same cycle as a hitting hm_hash_done → no found_valid, hm_quit next cycle, then IDLE. A job_valid asserted mid-job is ignored.
- Reset mid-job: rst during WAIT → next cycle all outputs 0, job_ready=1, no hm_quit issued.
